// File: rtl/requant_pipe_if.sv
// Stream interface for requant_pipe.
// Carries the accumulator input stream (valid/ready/data/last) and the
// quantised output stream (valid/ready/data/channel/saturation flag).
//   master : producer of input samples and consumer of outputs
//   slave  : the requantiser itself
interface requant_pipe_if #(
    parameter int ACC_W = 15,
    parameter int OUT_W = 4,
    parameter int CH_W  = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CH_W-1:0]  out_ch;
    logic             out_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_sat
    );
endinterface

// File: rtl/requant_pipe.sv
// Per-channel requantiser: maps signed accumulator samples to unsigned
// OUT_W activations, q = clamp(round(acc*scale >> shift) + zp, 0, 2^OUT_W-1).
// Three register stages (product, rounded shift, offset+clamp) that all
// advance together when the output slot is free or being consumed.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   cfg_*_i        per-channel config table write port (scale, shift, zp)
//   sat_clr_i      synchronous clear of the saturation counter
//   sat_cnt_o      saturating count of emitted samples that were clamped
//   bus            stream interface (slave side): input samples and outputs
module requant_pipe #(
    parameter int  ACC_W   = 15,
    parameter int  SCALE_W = 16,
    parameter int  SHIFT_W = 4,
    parameter int  OUT_W   = 4,
    parameter int  NUM_CH  = 4,
    parameter int  CNT_W   = 16,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we_i,
    input  logic [CH_W-1:0]    cfg_ch_i,
    input  logic [SCALE_W-1:0] cfg_scale_i,
    input  logic [SHIFT_W-1:0] cfg_shift_i,
    input  logic [OUT_W-1:0]   cfg_zp_i,
    input  logic               sat_clr_i,
    output logic [CNT_W-1:0]   sat_cnt_o,
    requant_pipe_if.slave      bus
);
    localparam int P_W = ACC_W + SCALE_W;  // exact product width
    localparam int R_W = P_W + 1;          // product plus rounding constant
    localparam int V_W = R_W + 1;          // rounded value plus zero point

    // Config table
    logic signed [SCALE_W-1:0] scale_q [NUM_CH];
    logic        [SHIFT_W-1:0] shift_q [NUM_CH];
    logic        [OUT_W-1:0]   zp_q    [NUM_CH];

    // Channel counter
    logic [CH_W-1:0] ch_q;
    logic [CH_W-1:0] ch_d;

    // Stage 1: product and the parameters the sample carries along
    logic                      s1_valid_q;
    logic [CH_W-1:0]           s1_ch_q;
    logic signed [P_W-1:0]     s1_p_q;
    logic signed [P_W-1:0]     s1_p_d;
    logic [SHIFT_W-1:0]        s1_shift_q;
    logic [OUT_W-1:0]          s1_zp_q;

    // Stage 2: rounded, shifted value
    logic                      s2_valid_q;
    logic [CH_W-1:0]           s2_ch_q;
    logic signed [R_W-1:0]     s2_r_q;
    logic signed [R_W-1:0]     s2_r_d;
    logic [OUT_W-1:0]          s2_zp_q;

    // Stage 3: output registers
    logic                      out_valid_q;
    logic [OUT_W-1:0]          out_data_q;
    logic [OUT_W-1:0]          out_data_d;
    logic [CH_W-1:0]           out_ch_q;
    logic                      out_sat_q;
    logic                      out_sat_d;

    logic [CNT_W-1:0]          sat_cnt_q;
    logic [CNT_W-1:0]          sat_cnt_d;

    logic                      adv_s;
    logic                      acc_s;
    logic                      cfg_hit_s;
    logic signed [P_W-1:0]     mul_a_s;
    logic signed [P_W-1:0]     mul_b_s;
    logic signed [R_W-1:0]     rnd_s;
    logic signed [R_W-1:0]     sum_s;
    logic signed [V_W-1:0]     v_s;

    // Flow control, channel sequencing and saturation counter next state.
    always_comb begin
        adv_s     = !out_valid_q || bus.out_ready;
        acc_s     = bus.in_valid && adv_s;
        cfg_hit_s = cfg_we_i && ({1'b0, cfg_ch_i} < (CH_W+1)'(NUM_CH));

        ch_d = ch_q;
        if (acc_s) begin
            if (bus.in_last || (ch_q == CH_W'(NUM_CH - 1))) begin
                ch_d = '0;
            end else begin
                ch_d = ch_q + {{(CH_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ch_d = ch_q;
        end

        sat_cnt_d = sat_cnt_q;
        if (sat_clr_i) begin
            sat_cnt_d = '0;
        end else if (out_valid_q && bus.out_ready && out_sat_q
                     && (sat_cnt_q != {CNT_W{1'b1}})) begin
            sat_cnt_d = sat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // Datapath: multiply, round-half-up arithmetic shift, offset and clamp.
    always_comb begin
        // Table read happens before this edge's write lands, so a same-cycle
        // write to the accepted sample's channel is not seen by that sample.
        mul_a_s = P_W'($signed(bus.in_data));
        mul_b_s = P_W'(scale_q[ch_q]);
        s1_p_d  = mul_a_s * mul_b_s;

        rnd_s = '0;
        if (s1_shift_q != '0) begin
            rnd_s = {{(R_W-1){1'b0}}, 1'b1} << (s1_shift_q - {{(SHIFT_W-1){1'b0}}, 1'b1});
        end else begin
            rnd_s = '0;
        end
        sum_s  = R_W'(s1_p_q) + rnd_s;
        s2_r_d = sum_s >>> s1_shift_q;

        v_s        = V_W'(s2_r_q) + $signed({{(V_W-OUT_W){1'b0}}, s2_zp_q});
        out_data_d = '0;
        out_sat_d  = 1'b0;
        if (v_s[V_W-1]) begin
            out_data_d = '0;
            out_sat_d  = 1'b1;
        end else if (|v_s[V_W-2:OUT_W]) begin
            out_data_d = '1;
            out_sat_d  = 1'b1;
        end else begin
            out_data_d = v_s[OUT_W-1:0];
            out_sat_d  = 1'b0;
        end
    end

    // Config table storage; defaults are identity scaling with no offset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                scale_q[i] <= SCALE_W'(1);
                shift_q[i] <= '0;
                zp_q[i]    <= '0;
            end
        end else if (cfg_hit_s) begin
            scale_q[cfg_ch_i] <= cfg_scale_i;
            shift_q[cfg_ch_i] <= cfg_shift_i;
            zp_q[cfg_ch_i]    <= cfg_zp_i;
        end
    end

    // Pipeline stages, channel counter and saturation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q        <= '0;
            sat_cnt_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_p_q      <= '0;
            s1_shift_q  <= '0;
            s1_zp_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_ch_q     <= '0;
            s2_r_q      <= '0;
            s2_zp_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            ch_q      <= ch_d;
            sat_cnt_q <= sat_cnt_d;
            // Whole pipe moves as one; a stalled output freezes every stage.
            if (adv_s) begin
                s1_valid_q  <= acc_s;
                s1_ch_q     <= ch_q;
                s1_p_q      <= s1_p_d;
                s1_shift_q  <= shift_q[ch_q];
                s1_zp_q     <= zp_q[ch_q];
                s2_valid_q  <= s1_valid_q;
                s2_ch_q     <= s1_ch_q;
                s2_r_q      <= s2_r_d;
                s2_zp_q     <= s1_zp_q;
                out_valid_q <= s2_valid_q;
                out_data_q  <= out_data_d;
                out_ch_q    <= s2_ch_q;
                out_sat_q   <= out_sat_d;
            end
        end
    end

    assign bus.in_ready  = adv_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_sat   = out_sat_q;
    assign sat_cnt_o     = sat_cnt_q;
endmodule

// File: tb/tb_requant_pipe.sv
// Testbench for requant_pipe: directed scenarios plus a randomized stream,
// checked by a scoreboard fed from an arithmetic reference model.
module tb_requant_pipe;
    localparam int NUM_CH = 4;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] ch;
        logic       sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_scale;
    logic [3:0]  cfg_shift;
    logic [3:0]  cfg_zp;
    logic        sat_clr;
    logic [15:0] sat_cnt;

    requant_pipe_if #(.ACC_W(15), .OUT_W(4), .CH_W(2)) bus ();

    requant_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we_i    (cfg_we),
        .cfg_ch_i    (cfg_ch),
        .cfg_scale_i (cfg_scale),
        .cfg_shift_i (cfg_shift),
        .cfg_zp_i    (cfg_zp),
        .sat_clr_i   (sat_clr),
        .sat_cnt_o   (sat_cnt),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;  // 0: always ready, 1: random, 2: never
    exp_t exp_q[$];
    int   m_scale [NUM_CH];
    int   m_shift [NUM_CH];
    int   m_zp    [NUM_CH];
    int   m_ch;
    int   m_sat;

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact integer arithmetic, floor division for the shift.
    function automatic exp_t ref_model(input int acc, input int scale, input int shift, input int zp);
        longint p, num, d, r, v;
        exp_t e;
        p   = longint'(acc) * longint'(scale);
        d   = longint'(1) << shift;
        num = (shift == 0) ? p : p + d / 2;
        r   = num / d;
        if ((num % d != 0) && (num < 0)) r = r - 1;
        v = r + zp;
        e.ch = 2'd0;
        if (v < 0) begin
            e.data = 4'd0;  e.sat = 1'b1;
        end else if (v > 15) begin
            e.data = 4'd15; e.sat = 1'b1;
        end else begin
            e.data = 4'(v); e.sat = 1'b0;
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_scale[i] = 1; m_shift[i] = 0; m_zp[i] = 0;
        end
        m_ch  = 0;
        m_sat = 0;
        exp_q.delete();
    endtask

    // Output-ready driver.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Reference model: observes accepts and config writes, pushes expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.in_valid && bus.in_ready) begin
                    e = ref_model(int'($signed(bus.in_data)), m_scale[m_ch], m_shift[m_ch], m_zp[m_ch]);
                    e.ch = 2'(m_ch);
                    exp_q.push_back(e);
                    m_ch = bus.in_last ? 0 : (m_ch + 1) % NUM_CH;
                end
                if (cfg_we) begin
                    m_scale[cfg_ch] = int'($signed(cfg_scale));
                    m_shift[cfg_ch] = int'(cfg_shift);
                    m_zp[cfg_ch]    = int'(cfg_zp);
                end
            end
        end
    end

    // Monitor: scoreboard compare, stall stability, saturation counter.
    initial begin
        exp_t       e;
        logic       held_v = 1'b0;
        logic [6:0] held;
        logic       pop_sat;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                chk("sat_cnt", sat_cnt, m_sat);
                if (held_v)
                    chk("stall_stable", {bus.out_valid, bus.out_data, bus.out_ch, bus.out_sat}, {1'b1, held});
                held_v  = 1'b0;
                pop_sat = 1'b0;
                if (bus.out_valid && !bus.out_ready) begin
                    held_v = 1'b1;
                    held   = {bus.out_data, bus.out_ch, bus.out_sat};
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", bus.out_data, e.data);
                        chk("out_ch", bus.out_ch, e.ch);
                        chk("out_sat", bus.out_sat, e.sat);
                        pop_sat = e.sat;
                    end
                end
                if (sat_clr) m_sat = 0;
                else if (pop_sat && m_sat != 65535) m_sat++;
            end
        end
    end

    task automatic cfg(input int ch, input int scale, input int shift, input int zp);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_scale = 16'(scale);
        cfg_shift = 4'(shift); cfg_zp = 4'(zp);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input int d, input logic last);
        int guard = 0;
        bus.in_valid = 1'b1; bus.in_data = 15'(d); bus.in_last = last;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            guard++;
            if (guard > 200) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic expect_out(input string name, input int d, input int ch, input int sat);
        int guard = 0;
        while (!bus.out_valid && guard < 20) begin
            @(negedge clk); guard++;
        end
        chk({name, "_valid"}, bus.out_valid, 1);
        chk({name, "_data"}, bus.out_data, d);
        chk({name, "_ch"}, bus.out_ch, ch);
        chk({name, "_sat"}, bus.out_sat, sat);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && guard < 300) begin
            @(negedge clk); guard++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0; cfg_we = 1'b0; sat_clr = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ch_seq [10] = '{0, 1, 2, 0, 1, 2, 3, 0, 1, 2};
        logic pend;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_scale = '0; cfg_shift = '0; cfg_zp = '0;
        sat_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_data", bus.out_data, 0);
        chk("reset_out_ch", bus.out_ch, 0);
        chk("reset_sat_cnt", sat_cnt, 0);
        @(posedge clk); #1;

        // 1: 5*3 = 15, >>1 with rounding -> 8, three cycles after accept
        cfg(0, 3, 1, 0);
        bus.in_valid = 1'b1; bus.in_data = 15'd5; bus.in_last = 1'b1;
        @(negedge clk);
        chk("t1_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("t1_not_early", bus.out_valid, 0);
        @(negedge clk);
        chk("t1_latency", bus.out_valid, 1);
        chk("t1_data", bus.out_data, 8);
        chk("t1_ch", bus.out_ch, 0);
        chk("t1_sat", bus.out_sat, 0);
        @(posedge clk); #1;

        // 2: zero point offsets
        cfg(0, 3, 1, 8);
        send(-5, 1'b1);
        expect_out("t2_neg", 1, 0, 0);
        send(0, 1'b1);
        expect_out("t2_zero", 8, 0, 0);

        // 3: clamping both ways and the saturation counter
        cfg(0, 1, 0, 0);
        send(100, 1'b1);
        expect_out("t3_hi", 15, 0, 1);
        cfg(0, 1, 0, 8);
        send(-100, 1'b1);
        expect_out("t3_lo", 0, 0, 1);
        @(negedge clk);
        chk("t3_sat_cnt", sat_cnt, 2);
        @(posedge clk); #1;
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        @(negedge clk);
        chk("t3_sat_clr", sat_cnt, 0);
        @(posedge clk); #1;

        // 4: in_last on the third sample restarts channel numbering; no gaps
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = 15'($urandom_range(0, 30));
                    bus.in_last  = (i == 2);
                    @(negedge clk);
                    chk("t4_in_ready", bus.in_ready, 1);
                    @(posedge clk); #1;
                end
                bus.in_valid = 1'b0; bus.in_last = 1'b0;
            end
            begin
                int wait_n = 0;
                int run = 0;
                while (!bus.out_valid && wait_n < 30) begin
                    @(negedge clk); wait_n++;
                end
                while (bus.out_valid && run < 12) begin
                    if (run < 10) chk("t4_ch_seq", bus.out_ch, ch_seq[run]);
                    run++;
                    @(negedge clk);
                end
                chk("t4_gapless_run", run, 10);
            end
        join
        wait_drain("t4_drain");
        @(posedge clk); #1;

        // 5: random stream, random config writes and backpressure
        pend = 1'b0;
        rdy_mode = 1;
        for (int n = 0; n < 300; n++) begin
            if (n == 100) rdy_mode = 2;
            if (n == 105) rdy_mode = 1;
            if (!pend) begin
                bus.in_valid = 1'b0;
                if ($urandom_range(0, 3) != 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = ($urandom_range(0, 1) != 0) ? 15'($urandom)
                                                               : 15'(int'($urandom_range(0, 60)) - 30);
                    bus.in_last  = ($urandom_range(0, 4) == 0);
                    pend = 1'b1;
                end
            end
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_ch    = 2'($urandom);
            cfg_scale = ($urandom_range(0, 1) != 0) ? 16'($urandom)
                                                    : 16'(int'($urandom_range(0, 8)) - 4);
            cfg_shift = 4'($urandom);
            cfg_zp    = 4'($urandom);
            sat_clr   = ($urandom_range(0, 40) == 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) pend = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; cfg_we = 1'b0; sat_clr = 1'b0;
        rdy_mode = 0;
        wait_drain("t5_drain");
        @(posedge clk); #1;

        // 6: reset with three samples in flight
        cfg(1, 5, 2, 3);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 15'(i + 1); bus.in_last = 1'b0;
            @(negedge clk);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        do_reset();
        chk("t6_queue_flushed", exp_q.size(), 0);
        @(negedge clk);
        chk("t6_out_valid_low", bus.out_valid, 0);
        @(posedge clk); #1;
        send(7, 1'b0);
        expect_out("t6_post", 7, 0, 0);
        wait_drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
